// File: rtl/pcd8544_pkg.sv
// PCD8544 receive-side constants: geometry, opcode masks and FSM states.
// Shared by the frame-buffer mirror and its RAM.
package pcd8544_pkg;

   localparam int COLS   = 84;
   localparam int ROWS   = 6;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = COLS * ROWS;

   localparam logic [7:0] FUNC_SET_M  = 8'hF8;
   localparam logic [7:0] FUNC_SET    = 8'h20;
   localparam logic [7:0] DISP_CTRL_M = 8'hFA;
   localparam logic [7:0] DISP_CTRL   = 8'h08;
   localparam logic [7:0] SET_Y_M     = 8'hF8;
   localparam logic [7:0] SET_Y       = 8'h40;
   localparam logic [7:0] SET_X_M     = 8'h80;
   localparam logic [7:0] SET_X       = 8'h80;
   localparam logic [7:0] TEMP_CTRL_M = 8'hFC;
   localparam logic [7:0] TEMP_CTRL   = 8'h04;
   localparam logic [7:0] BIAS_SET_M  = 8'hF8;
   localparam logic [7:0] BIAS_SET    = 8'h10;
   localparam logic [7:0] SET_VOP_M   = 8'h80;
   localparam logic [7:0] SET_VOP     = 8'h80;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      IDLE  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   function automatic logic op_is(
      input logic [7:0] b,
      input logic [7:0] m,
      input logic [7:0] v
   );
      return (b & m) == v;
   endfunction

   function automatic logic [ADDR_W-1:0] cell_addr(
      input logic [6:0] x,
      input logic [2:0] y
   );
      return ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);
   endfunction

endpackage

// File: rtl/nokia_fb_ram.sv
// 504x8 frame buffer: one write port, one synchronous read port.
// A read colliding with a write returns the old contents.
module nokia_fb_ram
   import pcd8544_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     rd_data <= '0;
      else if (clr) rd_data <= '0;
      else          rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/nokia5110_receiver.sv
// Snoops a PCD8544 serial bus, decodes commands into mode registers and
// mirrors written data bytes into an on-chip frame buffer.
module nokia5110_receiver
   import pcd8544_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lcd_rst,
   input  logic              ce,
   input  logic              dc,
   input  logic              din,
   input  logic              dclk,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              byte_valid,
   output logic [7:0]        byte_out,
   output logic              byte_is_data,
   output logic [6:0]        cur_x,
   output logic [2:0]        cur_y,
   output logic              ext_mode,
   output logic              vertical,
   output logic              power_down,
   output logic [1:0]        disp_mode,
   output logic [6:0]        vop,
   output logic [1:0]        tc,
   output logic [2:0]        bias,
   output logic              frame_done
);

   localparam logic [6:0] LAST_X = 7'(COLS - 1);
   localparam logic [2:0] LAST_Y = 3'(ROWS - 1);

   // Sync order {lcd_rst, ce, dc, din, dclk}; idle bus = ce high, in reset
   logic [4:0] sync_q [SYNC_STAGES];
   logic       lcd_s, ce_s, dc_s, din_s, dclk_s, dclk_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 5'b01000;
         dclk_q <= 1'b0;
      end else begin
         sync_q[0] <= {lcd_rst, ce, dc, din, dclk};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         dclk_q <= dclk_s;
      end
   end

   assign {lcd_s, ce_s, dc_s, din_s, dclk_s} = sync_q[SYNC_STAGES-1];

   state_t     state_q, state_d;
   logic [2:0] cnt;
   logic [6:0] shreg;
   logic       rise, got;
   logic [7:0] nb;

   assign rise = dclk_s & ~dclk_q;
   assign got  = (state_q == SHIFT) & lcd_s & ~ce_s & rise & (cnt == 3'd7);
   assign nb   = {shreg, din_s};

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HOLD:    if (lcd_s) state_d = IDLE;
         IDLE:    if (!ce_s) state_d = SHIFT;
         SHIFT:   if (ce_s) state_d = IDLE;
         default: state_d = HOLD;
      endcase
      if (!lcd_s) state_d = HOLD;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= HOLD;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (!lcd_s || ce_s || state_q != SHIFT) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (rise) begin
         cnt   <= cnt + 3'd1;
         shreg <= nb[6:0];
      end
   end

   logic [6:0] x_d, vop_d;
   logic [2:0] y_d, bias_d;
   logic [1:0] dm_d, tc_d;
   logic [7:0] bo_d;
   logic       h_d, v_d, pd_d, fd_d, bd_d;

   always_comb begin
      x_d    = cur_x;
      y_d    = cur_y;
      h_d    = ext_mode;
      v_d    = vertical;
      pd_d   = power_down;
      dm_d   = disp_mode;
      vop_d  = vop;
      tc_d   = tc;
      bias_d = bias;
      bo_d   = byte_out;
      bd_d   = byte_is_data;
      fd_d   = 1'b0;
      if (got) begin
         bo_d = nb;
         bd_d = dc_s;
      end
      if (got && dc_s) begin
         if (!vertical) begin
            if (cur_x == LAST_X) begin
               x_d = '0;
               if (cur_y == LAST_Y) begin
                  y_d  = '0;
                  fd_d = 1'b1;
               end else y_d = cur_y + 3'd1;
            end else x_d = cur_x + 7'd1;
         end else begin
            if (cur_y == LAST_Y) begin
               y_d = '0;
               if (cur_x == LAST_X) begin
                  x_d  = '0;
                  fd_d = 1'b1;
               end else x_d = cur_x + 7'd1;
            end else y_d = cur_y + 3'd1;
         end
      end else if (got) begin
         unique case (1'b1)
            op_is(nb, FUNC_SET_M, FUNC_SET):
               {pd_d, v_d, h_d} = nb[2:0];
            !ext_mode && op_is(nb, DISP_CTRL_M, DISP_CTRL):
               dm_d = {nb[2], nb[0]};
            !ext_mode && op_is(nb, SET_Y_M, SET_Y):
               if (nb[2:0] <= LAST_Y) y_d = nb[2:0];
            !ext_mode && op_is(nb, SET_X_M, SET_X):
               if (nb[6:0] <= LAST_X) x_d = nb[6:0];
            ext_mode && op_is(nb, TEMP_CTRL_M, TEMP_CTRL):
               tc_d = nb[1:0];
            ext_mode && op_is(nb, BIAS_SET_M, BIAS_SET):
               bias_d = nb[2:0];
            ext_mode && op_is(nb, SET_VOP_M, SET_VOP):
               vop_d = nb[6:0];
            default: ;
         endcase
      end
      // Display reset clears the same state as the block reset
      if (!lcd_s) begin
         x_d    = '0;
         y_d    = '0;
         h_d    = 1'b0;
         v_d    = 1'b0;
         pd_d   = 1'b1;
         dm_d   = '0;
         vop_d  = '0;
         tc_d   = '0;
         bias_d = '0;
         bo_d   = '0;
         bd_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_x        <= '0;
         cur_y        <= '0;
         ext_mode     <= 1'b0;
         vertical     <= 1'b0;
         power_down   <= 1'b1;
         disp_mode    <= '0;
         vop          <= '0;
         tc           <= '0;
         bias         <= '0;
         byte_out     <= '0;
         byte_is_data <= 1'b0;
         byte_valid   <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         cur_x        <= x_d;
         cur_y        <= y_d;
         ext_mode     <= h_d;
         vertical     <= v_d;
         power_down   <= pd_d;
         disp_mode    <= dm_d;
         vop          <= vop_d;
         tc           <= tc_d;
         bias         <= bias_d;
         byte_out     <= bo_d;
         byte_is_data <= bd_d;
         byte_valid   <= got;
         frame_done   <= fd_d;
      end
   end

   nokia_fb_ram u_ram (
      .clk     (clk),
      .rst     (rst),
      .clr     (~lcd_s),
      .we      (got & dc_s),
      .wr_addr (cell_addr(cur_x, cur_y)),
      .wr_data (nb),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_nokia5110_receiver.sv
// Bench for nokia5110_receiver: drives the serial bus and checks against
// a behavioural model of the PCD8544 command set and addressing.
module tb_nokia5110_receiver;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       lcd_rst = 1'b0;
   logic       ce = 1'b1;
   logic       dc = 1'b0;
   logic       din = 1'b0;
   logic       dclk = 1'b0;
   logic [8:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic       byte_valid;
   logic [7:0] byte_out;
   logic       byte_is_data;
   logic [6:0] cur_x;
   logic [2:0] cur_y;
   logic       ext_mode;
   logic       vertical;
   logic       power_down;
   logic [1:0] disp_mode;
   logic [6:0] vop;
   logic [1:0] tc;
   logic [2:0] bias;
   logic       frame_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nokia5110_receiver dut (
      .clk          (clk),
      .rst          (rst),
      .lcd_rst      (lcd_rst),
      .ce           (ce),
      .dc           (dc),
      .din          (din),
      .dclk         (dclk),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .byte_valid   (byte_valid),
      .byte_out     (byte_out),
      .byte_is_data (byte_is_data),
      .cur_x        (cur_x),
      .cur_y        (cur_y),
      .ext_mode     (ext_mode),
      .vertical     (vertical),
      .power_down   (power_down),
      .disp_mode    (disp_mode),
      .vop          (vop),
      .tc           (tc),
      .bias         (bias),
      .frame_done   (frame_done)
   );

   // Pulse counters
   int bv_cnt = 0;
   int fd_cnt = 0;
   int fd_at = -1;
   int fd_lone = 0;

   always @(negedge clk) begin
      if (byte_valid) bv_cnt++;
      if (frame_done) begin
         fd_cnt++;
         if (byte_valid) fd_at = bv_cnt;
         else fd_lone++;
      end
   end

   // Reference model
   int         mx, my, mfd;
   logic       mh, mv, mpd;
   logic [1:0] mdm, mtc;
   logic [6:0] mvop;
   logic [2:0] mbias;
   logic [7:0] mlast;
   logic       mlast_d;
   int         mmem [504];

   function automatic void model_reset();
      mx = 0; my = 0; mh = 0; mv = 0; mpd = 1;
      mdm = 0; mtc = 0; mvop = 0; mbias = 0;
      mlast = 0; mlast_d = 0;
   endfunction

   function automatic void model_byte(input logic d, input logic [7:0] b);
      mlast = b;
      mlast_d = d;
      if (d) begin
         mmem[my * 84 + mx] = int'(b);
         if (!mv) begin
            mx++;
            if (mx == 84) begin
               mx = 0; my++;
               if (my == 6) begin my = 0; mfd++; end
            end
         end else begin
            my++;
            if (my == 6) begin
               my = 0; mx++;
               if (mx == 84) begin mx = 0; mfd++; end
            end
         end
      end else if (b >= 8'h20 && b <= 8'h27) begin
         mpd = b[2]; mv = b[1]; mh = b[0];
      end else if (!mh) begin
         if (b >= 8'h08 && b <= 8'h0F && !b[1]) mdm = {b[2], b[0]};
         else if (b >= 8'h40 && b <= 8'h47) begin
            if (int'(b[2:0]) < 6) my = int'(b[2:0]);
         end else if (b >= 8'h80) begin
            if (int'(b[6:0]) < 84) mx = int'(b[6:0]);
         end
      end else begin
         if (b >= 8'h04 && b <= 8'h07) mtc = b[1:0];
         else if (b >= 8'h10 && b <= 8'h17) mbias = b[2:0];
         else if (b >= 8'h80) mvop = b[6:0];
      end
   endfunction

   task automatic send_bits(input logic [7:0] b, input int n);
      ce = 1'b0;
      for (int i = 7; i > 7 - n; i--) begin
         din = b[i];
         repeat (3) @(negedge clk);
         dclk = 1'b1;
         repeat (3) @(negedge clk);
         dclk = 1'b0;
      end
   endtask

   task automatic send_byte(input logic d, input logic [7:0] b);
      dc = d;
      send_bits(b, 8);
      repeat (4) @(negedge clk);
      model_byte(d, b);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (power_down !== 1'b1) begin
         errors++;
         $display("FAIL reset_pd got %0b want 1", power_down);
      end
      checks++;
      if ({byte_valid, byte_out, cur_x, cur_y, ext_mode, vertical,
           disp_mode, vop, tc, bias, frame_done, rd_data} !== '0) begin
         errors++;
         $display("FAIL reset_zero x=%0d y=%0d vop=%h bo=%h rd=%h want 0",
                  cur_x, cur_y, vop, byte_out, rd_data);
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      lcd_rst = 1'b1;
      repeat (5) @(negedge clk);
      model_reset();
   endtask

   task automatic test_lcd_rst();
      send_byte(0, 8'h21);
      send_byte(0, 8'hC7);
      ce = 1'b1;
      lcd_rst = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (vop !== 7'h00 || ext_mode !== 1'b0 || power_down !== 1'b1) begin
         errors++;
         $display("FAIL lcd_rst vop=%h h=%0b pd=%0b want 00 0 1",
                  vop, ext_mode, power_down);
      end
      lcd_rst = 1'b1;
      repeat (5) @(negedge clk);
      model_reset();
   endtask

   task automatic test_commands();
      int bv0;
      bv0 = bv_cnt;
      send_byte(0, 8'h21);
      checks++;
      if (ext_mode !== 1'b1) begin
         errors++;
         $display("FAIL cmd_ext1 got %0b want 1", ext_mode);
      end
      send_byte(0, 8'hC0);
      send_byte(0, 8'h20);
      checks++;
      if (bv_cnt - bv0 !== 3) begin
         errors++;
         $display("FAIL cmd_pulses got %0d want 3", bv_cnt - bv0);
      end
      checks++;
      if (vop !== 7'h40 || ext_mode !== 1'b0 || power_down !== 1'b0) begin
         errors++;
         $display("FAIL cmd_regs vop=%h h=%0b pd=%0b want 40 0 0",
                  vop, ext_mode, power_down);
      end
      checks++;
      if (byte_out !== mlast || byte_is_data !== mlast_d) begin
         errors++;
         $display("FAIL cmd_byte got %h/%0b want %h/%0b",
                  byte_out, byte_is_data, mlast, mlast_d);
      end
   endtask

   task automatic test_ignored();
      logic [6:0] x0;
      logic [2:0] y0;
      send_byte(0, 8'h0C);
      checks++;
      if (disp_mode !== 2'b10) begin
         errors++;
         $display("FAIL disp_mode got %b want 10", disp_mode);
      end
      x0 = 7'(mx);
      y0 = 3'(my);
      send_byte(0, 8'h46);
      send_byte(0, 8'hDA);
      checks++;
      if (cur_x !== x0 || cur_y !== y0) begin
         errors++;
         $display("FAIL oob_addr got %0d,%0d want %0d,%0d", cur_x, cur_y, x0, y0);
      end
   endtask

   task automatic test_set_addr();
      send_byte(0, 8'h42);
      send_byte(0, 8'h8A);
      send_byte(1, 8'hA5);
      @(negedge clk) rd_addr = 9'd178;
      @(posedge clk);
      #1;
      checks++;
      if (rd_data !== 8'hA5) begin
         errors++;
         $display("FAIL rd_178 got %h want a5", rd_data);
      end
      checks++;
      if (cur_x !== 7'd11 || cur_y !== 3'd2) begin
         errors++;
         $display("FAIL set_addr got %0d,%0d want 11,2", cur_x, cur_y);
      end
   endtask

   task automatic test_frame();
      int bv0, fd0;
      int addrs [3] = '{0, 300, 503};
      send_byte(0, 8'h20);
      send_byte(0, 8'h40);
      send_byte(0, 8'h80);
      bv0 = bv_cnt;
      fd0 = fd_cnt;
      for (int i = 0; i < 504; i++) send_byte(1, 8'(i));
      checks++;
      if (fd_cnt - fd0 !== 1 || fd_at !== bv0 + 504 || fd_lone !== 0) begin
         errors++;
         $display("FAIL frame_done n=%0d at=%0d lone=%0d want 1 %0d 0",
                  fd_cnt - fd0, fd_at, fd_lone, bv0 + 504);
      end
      checks++;
      if (cur_x !== 7'd0 || cur_y !== 3'd0) begin
         errors++;
         $display("FAIL frame_wrap got %0d,%0d want 0,0", cur_x, cur_y);
      end
      foreach (addrs[k]) begin
         @(negedge clk) rd_addr = 9'(addrs[k]);
         @(posedge clk);
         #1;
         checks++;
         if (rd_data !== 8'(addrs[k] % 256)) begin
            errors++;
            $display("FAIL frame_mem[%0d] got %h want %h",
                     addrs[k], rd_data, 8'(addrs[k] % 256));
         end
      end
   endtask

   task automatic test_vertical();
      int addrs [7] = '{0, 84, 168, 252, 336, 420, 1};
      logic [7:0] vals [7];
      send_byte(0, 8'h22);
      send_byte(0, 8'h40);
      send_byte(0, 8'h80);
      for (int i = 0; i < 7; i++) begin
         vals[i] = 8'($urandom_range(0, 255));
         send_byte(1, vals[i]);
      end
      checks++;
      if (cur_x !== 7'd1 || cur_y !== 3'd1) begin
         errors++;
         $display("FAIL vert_addr got %0d,%0d want 1,1", cur_x, cur_y);
      end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk) rd_addr = 9'(addrs[i]);
         @(posedge clk);
         #1;
         checks++;
         if (rd_data !== vals[i]) begin
            errors++;
            $display("FAIL vert_mem[%0d] got %h want %h", addrs[i], rd_data, vals[i]);
         end
      end
   endtask

   task automatic test_partial();
      int bv0;
      send_byte(0, 8'h20);
      bv0 = bv_cnt;
      dc = 1'b0;
      send_bits(8'hFF, 5);
      ce = 1'b1;
      repeat (5) @(negedge clk);
      send_byte(0, 8'h0D);
      checks++;
      if (bv_cnt - bv0 !== 1) begin
         errors++;
         $display("FAIL partial_pulses got %0d want 1", bv_cnt - bv0);
      end
      checks++;
      if (disp_mode !== 2'b11) begin
         errors++;
         $display("FAIL partial_disp got %b want 11", disp_mode);
      end
   endtask

   task automatic test_random();
      logic       d;
      logic [7:0] b;
      int         a, seen;
      for (int n = 0; n < 160; n++) begin
         d = 1'($urandom_range(0, 1));
         b = 8'($urandom_range(0, 255));
         send_byte(d, b);
         checks++;
         if (cur_x !== 7'(mx) || cur_y !== 3'(my)) begin
            errors++;
            $display("FAIL rnd_addr n=%0d byte=%h got %0d,%0d want %0d,%0d",
                     n, b, cur_x, cur_y, mx, my);
         end
      end
      checks++;
      if ({ext_mode, vertical, power_down, disp_mode, vop, tc, bias}
          !== {mh, mv, mpd, mdm, mvop, mtc, mbias}) begin
         errors++;
         $display("FAIL rnd_regs got h%0b v%0b pd%0b dm%b vop%h tc%b b%b want h%0b v%0b pd%0b dm%b vop%h tc%b b%b",
                  ext_mode, vertical, power_down, disp_mode, vop, tc, bias,
                  mh, mv, mpd, mdm, mvop, mtc, mbias);
      end
      checks++;
      if (fd_cnt !== mfd) begin
         errors++;
         $display("FAIL rnd_frames got %0d want %0d", fd_cnt, mfd);
      end
      a = $urandom_range(0, 503);
      seen = 0;
      for (int k = 0; k < 504 && seen < 8; k++) begin
         if (mmem[(a + k) % 504] >= 0) begin
            seen++;
            @(negedge clk) rd_addr = 9'((a + k) % 504);
            @(posedge clk);
            #1;
            checks++;
            if (rd_data !== 8'(mmem[(a + k) % 504])) begin
               errors++;
               $display("FAIL rnd_mem[%0d] got %h want %h",
                        (a + k) % 504, rd_data, 8'(mmem[(a + k) % 504]));
            end
         end
      end
   endtask

   task automatic test_rst_mid_byte();
      int bv0;
      send_byte(0, 8'h21);
      send_byte(0, 8'hC5);
      send_byte(0, 8'h21);
      checks++;
      if (vop !== 7'h45 || ext_mode !== 1'b1) begin
         errors++;
         $display("FAIL pre_rst vop=%h h=%0b want 45 1", vop, ext_mode);
      end
      bv0 = bv_cnt;
      dc = 1'b1;
      send_bits(8'h3C, 4);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (power_down !== 1'b1) begin
         errors++;
         $display("FAIL rst_async_pd got %0b want 1", power_down);
      end
      checks++;
      if ({byte_valid, byte_out, byte_is_data, cur_x, cur_y, ext_mode,
           vertical, disp_mode, vop, tc, bias, frame_done, rd_data} !== '0) begin
         errors++;
         $display("FAIL rst_async_zero vop=%h h=%0b x=%0d bo=%h rd=%h want 0",
                  vop, ext_mode, cur_x, byte_out, rd_data);
      end
      ce = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (bv_cnt !== bv0) begin
         errors++;
         $display("FAIL rst_no_byte got %0d want %0d", bv_cnt - bv0, 0);
      end
   endtask

   initial begin
      foreach (mmem[i]) mmem[i] = -1;
      mfd = 0;
      model_reset();
      test_reset();
      test_lcd_rst();
      test_commands();
      test_ignored();
      test_set_addr();
      test_frame();
      test_vertical();
      test_partial();
      test_random();
      test_rst_mid_byte();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
